mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shared-memory arbiter between N compute cores and the single 1024x16 word memory port in the top level. Sits directly downstream of each core's memory address/data pins. It serialises the cores' load/store requests onto the memory with round-robin fairness, which lets SPWN-launched cores share one memory. Each access is a fixed 3-cycle transaction; read data and acknowledge return to the winning core only.

Parameters:
NCORES, 4, number of requesting cores (2..8)
ADDR_W, 10, word address width (1024 words)
DATA_W, 16, memory word width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
req  in  NCORES  per-core request; held high with stable fields until ack
we  in  NCORES  per-core write enable (1=store, 0=load), qualified by req
addr  in  NCORES*ADDR_W  per-core word address, core i at bits [i*ADDR_W +: ADDR_W]
wdata  in  NCORES*DATA_W  per-core store data, same packing
ack  out  NCORES  one-cycle completion pulse, at most one bit set
rdata  out  DATA_W  response word, shared, valid when any ack bit high
mem_addr  out  ADDR_W  memory address (registered)
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  combinational memory read of mem_addr

Behaviour:
- Reset values: state=IDLE, ptr=0, sel=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0.
- FSM: IDLE -> ACCESS -> RESP -> IDLE; no other transitions except reset.
- IDLE (cycle t): if req != 0, pick the winner as the first set req bit at or after ptr, wrapping modulo NCORES. Latch sel=winner, mem_addr=addr[sel], mem_wdata=wdata[sel], lwe=we[sel]; go to ACCESS. If req == 0, stay in IDLE.
- ACCESS (t+1): mem_we = lwe (combinational, also gated by !reset). Register rdata = lwe ? mem_wdata : mem_rdata. Register ack = one-hot(sel). Set ptr = (sel+1) mod NCORES. Go to RESP.
- RESP (t+2): ack high exactly this cycle, rdata valid. No arbitration in RESP, so the core drops req at t+3 without a double grant. Go to IDLE. At t+3, ack=0; rdata holds its value until the next ACCESS.
- Latency: request seen in IDLE at t -> ack at t+2. Throughput is 1 access per 3 cycles. Worst-case wait for any core is NCORES*3 cycles.
- On a store, rdata echoes the written data (write-through). Memory is written exactly once per store, in the ACCESS cycle.
- req deasserted before ack: the transaction still completes as latched, and the ack is still issued.
- Simultaneous requests: only the round-robin winner is served; the others wait in IDLE arbitration.
- Wrap: ptr=NCORES-1 with sel=NCORES-1 -> ptr=0.
- Reset mid-transaction: the next state is IDLE with all outputs at reset values. A store in ACCESS during reset is suppressed (mem_we=0), and no ack is issued.
- ack is never X after reset; a bit in ack is only set for a core whose req was high when it won.

Decomposition:
- Shared package/include: ADDR_W and DATA_W defaults, FSM state encodings (IDLE=0, ACCESS=1, RESP=2), and a MEM_WORDS=1024 constant shared with the top-level memory declaration.
- One sub-module, rr_picker: a combinational round-robin priority encoder. Inputs are req[NCORES] and ptr; outputs are any and idx.
- The FSM, latches and response register live in mem_arbiter.

Test Plan:
- Single load: memory[5]=16'h1234, core0 req=1 we=0 addr=5 at t -> ack=4'b0001 and rdata=16'h1234 at t+2; no mem_we pulse.
- Single store: core2 store addr=7 wdata=16'hBEEF -> mem_we=1 with mem_addr=7 at t+1; ack=4'b0100 and rdata=16'hBEEF at t+2; a later load of addr 7 returns 16'hBEEF.
- Round-robin: all 4 cores hold load requests after reset -> acks in order core0,1,2,3,0 at cycles t+2, t+5, t+8, t+11, t+14.
- Wrap/fairness: ptr=3 (after core2 served), req=4'b1001 -> core3 served first, then core0.
- Reset mid-transaction: core1 store to addr 3 (memory[3]=0), reset asserted in the ACCESS cycle -> mem_we=0, memory[3] stays 0, no ack, state IDLE, ptr=0.
- Idle: req=0 for 20 cycles -> ack=0 and mem_we=0 throughout; mem_addr holds its last value.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared constants and FSM encoding for the memory arbiter
package mem_arbiter_pkg;

    localparam int NCORES_DEF = 4;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int MEM_WORDS  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - core-side request/response bus of the memory arbiter
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NCORES-1:0]        req;
    logic [NCORES-1:0]        we;
    logic [NCORES*ADDR_W-1:0] addr;
    logic [NCORES*DATA_W-1:0] wdata;
    logic [NCORES-1:0]        ack;
    logic [DATA_W-1:0]        rdata;

    // cores drive requests and receive the response
    modport master (output req, we, addr, wdata, input ack, rdata);
    // the arbiter consumes requests and returns the response
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin priority encoder
module rr_picker #(
    parameter int NCORES = 4,
    parameter int PTR_W  = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic [NCORES-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic              o_any,
    output logic [PTR_W-1:0]  o_idx
);
    int               w_cand;
    logic [PTR_W-1:0] w_cidx;

    // scan from farthest to nearest so the first set bit at/after i_ptr wins
    always_comb begin
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = 0;
        w_cidx = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= NCORES) begin
                w_cand = w_cand - NCORES;
            end
            w_cidx = PTR_W'(w_cand);
            if (i_req[w_cidx]) begin
                o_any = 1'b1;
                o_idx = w_cidx;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter serialising core loads/stores onto one memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    localparam int PTR_W = (NCORES > 1) ? $clog2(NCORES) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_sel;
    logic              r_lwe;
    logic [NCORES-1:0] r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_any;
    logic [PTR_W-1:0]  w_win;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;
    logic              w_mem_we;

    rr_picker #(.NCORES(NCORES), .PTR_W(PTR_W)) u_picker (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_win)
    );

    assign w_addr_sel  = bus.addr[int'(w_win) * ADDR_W +: ADDR_W];
    assign w_wdata_sel = bus.wdata[int'(w_win) * DATA_W +: DATA_W];

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next state and the memory write strobe; the strobe is killed by reset so
    // a store caught mid-transaction never reaches memory
    always_comb begin
        w_next_state = r_state;
        w_mem_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_we     = r_lwe & ~i_reset;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // winner latch in IDLE; response and pointer update in ACCESS
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr       <= '0;
            r_sel       <= '0;
            r_lwe       <= 1'b0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel       <= w_win;
                        r_mem_addr  <= w_addr_sel;
                        r_mem_wdata <= w_wdata_sel;
                        r_lwe       <= bus.we[w_win];
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= r_lwe ? r_mem_wdata : i_mem_rdata;
                    r_ack   <= NCORES'(1) << r_sel;
                    r_ptr   <= (r_sel == PTR_W'(NCORES - 1)) ? '0 : r_sel + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ack     = r_ack;
    assign bus.rdata   = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_we    = w_mem_we;
    assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem [MEM_WORDS];

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    mem_arbiter #(.NCORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .bus         (bus.slave),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // ---------------- behavioural model ----------------
    // Transactions are scheduled as future events: a grant decided while the
    // arbiter is free produces a memory write one cycle later and an ack plus
    // response word two cycles later; the arbiter is free again three cycles on.
    logic [DW-1:0] m_mem [MEM_WORDS];
    logic [N-1:0]  ack_q [4];
    logic          we_q  [4];
    logic [AW-1:0] wa_q  [4];
    logic [DW-1:0] wd_q  [4];
    logic [DW-1:0] rd_q  [4];
    int            m_ptr = 0;
    int            free_cyc = 0;
    int            mcyc = 0;
    bit            m_on = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    always @(negedge clk) begin
        int s, s1, s2, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        s = mcyc % 4;
        if (m_on) begin
            if (ack_q[s] != '0) m_rdata = rd_q[s];
            chk("model ack", 32'(bus.ack), 32'(ack_q[s]));
            chk("model mem_we", 32'(mem_we), 32'(we_q[s] && !reset));
            chk("model rdata", 32'(bus.rdata), 32'(m_rdata));
            chk("model mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("model mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            if (we_q[s] && !reset) m_mem[wa_q[s]] = wd_q[s];
        end
        ack_q[s] = '0;
        we_q[s]  = 1'b0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                ack_q[i] = '0;
                we_q[i]  = 1'b0;
            end
            m_ptr    = 0;
            m_rdata  = '0;
            m_addr   = '0;
            m_wdata  = '0;
            free_cyc = mcyc + 1;
            m_on     = 1'b1;
        end else if (m_on && mcyc >= free_cyc && bus.req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            a  = bus.addr[w*AW +: AW];
            d  = bus.wdata[w*DW +: DW];
            s1 = (mcyc + 1) % 4;
            s2 = (mcyc + 2) % 4;
            we_q[s1]  = bus.we[w];
            wa_q[s1]  = a;
            wd_q[s1]  = d;
            ack_q[s2] = N'(1) << w;
            rd_q[s2]  = bus.we[w] ? d : m_mem[a];
            m_addr    = a;
            m_wdata   = d;
            m_ptr     = (w + 1) % N;
            free_cyc  = mcyc + 3;
        end
        mcyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_core(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[i]          = w;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        mem[a]   = d;
        m_mem[a] = d;
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]   = '0;
            m_mem[i] = '0;
        end
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        repeat (3) tick();
        negs(1);
        chk("reset ack", 32'(bus.ack), 32'h0);
        chk("reset mem_we", 32'(mem_we), 32'h0);
        chk("reset rdata", 32'(bus.rdata), 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        tick(); reset = 1'b0;

        // single load: core0 addr 5
        preload(5, 16'h1234);
        tick(); set_core(0, 1'b0, 10'd5, 16'h0); bus.req = 4'b0001;
        negs(2);
        chk("load no mem_we", 32'(mem_we), 32'h0);
        negs(1);
        chk("load ack", 32'(bus.ack), 32'h1);
        chk("load rdata", 32'(bus.rdata), 32'h1234);
        tick(); bus.req = '0;

        // single store: core2 addr 7 data BEEF, then core1 reads it back
        tick(); set_core(2, 1'b1, 10'd7, 16'hBEEF); bus.req = 4'b0100;
        negs(2);
        chk("store mem_we", 32'(mem_we), 32'h1);
        chk("store mem_addr", 32'(mem_addr), 32'd7);
        negs(1);
        chk("store ack", 32'(bus.ack), 32'h4);
        chk("store rdata", 32'(bus.rdata), 32'hBEEF);
        tick(); bus.req = '0; set_core(2, 1'b0, 10'd0, 16'h0);
        chk("store mem[7]", 32'(mem[7]), 32'hBEEF);
        set_core(1, 1'b0, 10'd7, 16'h0); bus.req = 4'b0010;
        negs(3);
        chk("readback ack", 32'(bus.ack), 32'h2);
        chk("readback rdata", 32'(bus.rdata), 32'hBEEF);
        tick(); bus.req = '0;

        // round robin after reset: all cores hold loads
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            preload(20 + i, 16'h1000 + 16'(i));
            set_core(i, 1'b0, 10'(20 + i), 16'h0);
        end
        tick(); bus.req = 4'b1111;
        negs(3);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) negs(3);
            chk($sformatf("rr ack %0d", k), 32'(bus.ack), 32'(1 << (k % 4)));
            chk($sformatf("rr rdata %0d", k), 32'(bus.rdata), 32'h1000 + 32'(k % 4));
        end
        tick(); bus.req = '0;

        // wrap: core2 served brings ptr to 3, then req=1001 -> core3 then core0
        bus.req = 4'b0100;
        negs(3);
        chk("wrap pre ack", 32'(bus.ack), 32'h4);
        tick(); bus.req = 4'b1001;
        negs(3);
        chk("wrap first core3", 32'(bus.ack), 32'h8);
        tick(); bus.req = 4'b0001;
        negs(3);
        chk("wrap then core0", 32'(bus.ack), 32'h1);
        tick(); bus.req = '0;

        // reset while a store is in ACCESS
        preload(3, 16'h0000);
        set_core(1, 1'b1, 10'd3, 16'hAAAA); bus.req = 4'b0010;
        tick(); reset = 1'b1; bus.req = '0;
        negs(1);
        chk("rst mid mem_we", 32'(mem_we), 32'h0);
        tick(); reset = 1'b0;
        negs(1);
        chk("rst mid ack", 32'(bus.ack), 32'h0);
        chk("rst mid mem_addr", 32'(mem_addr), 32'h0);
        chk("rst mid mem[3]", 32'(mem[3]), 32'h0);
        set_core(0, 1'b0, 10'd9, 16'h0); set_core(3, 1'b0, 10'd21, 16'h0);
        tick(); bus.req = 4'b1001;
        negs(3);
        chk("rst ptr0 ack", 32'(bus.ack), 32'h1);
        chk("rst ptr0 mem_addr", 32'(mem_addr), 32'd9);
        tick(); bus.req = '0;

        // req dropped before ack: transaction still completes
        set_core(3, 1'b1, 10'd12, 16'h5A5A); bus.req = 4'b1000;
        tick(); bus.req = '0;
        negs(2);
        chk("drop ack", 32'(bus.ack), 32'h8);
        chk("drop rdata", 32'(bus.rdata), 32'h5A5A);
        tick();
        chk("drop mem[12]", 32'(mem[12]), 32'h5A5A);

        // idle for 20 cycles
        for (int c = 0; c < 20; c++) begin
            tick();
            negs(1);
            chk("idle ack", 32'(bus.ack), 32'h0);
            chk("idle mem_we", 32'(mem_we), 32'h0);
            chk("idle mem_addr", 32'(mem_addr), 32'd12);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
